// File: rtl/clint_multi.sv
// clint_multi: core-local interrupt controller that sequences traps and MRET into CSR writes and a redirect.
// Define CLINT_VECTOR_EN for vectored async trap targets when mtvec mode is 01.
module clint_multi #(
  parameter int NUM_IRQ = 8,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               div_started_i,
  input  logic [31:0]        csr_mtvec_i,
  input  logic [31:0]        csr_mepc_i,
  input  logic [31:0]        csr_mstatus_i,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [31:0]        waddr_o,
  output logic [31:0]        data_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [NUM_IRQ-1:0] irq_claim_o
);
  localparam int SW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET_INST = 32'h3020_0073;
  typedef enum logic [2:0] {IDLE, MEPC, MSTATUS, MCAUSE, ASSERT, MRET} state_t;
  state_t state;
  logic [31:0] mepc_q, cause_q, base, target;
  logic [SW-1:0] src, src_q;
  logic [NUM_IRQ-1:0] pending;
  logic async_q, mret_q, is_ecall, is_ebreak, sync_req, async_req, mret_req;
  assign pending = irq_i & irq_en_i;
  assign is_ecall = inst_i == ECALL;
  assign is_ebreak = inst_i == EBREAK;
  assign sync_req = (is_ecall | is_ebreak) & ~div_started_i;
  assign async_req = (|pending) & global_int_en_i;
  assign mret_req = inst_i == MRET_INST;
  assign hold_flag_o = state != IDLE || sync_req || async_req || mret_req;
  assign base = {csr_mtvec_i[31:2], 2'b00};
  always_comb begin
    src = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pending[i]) src = SW'(i);
  end
`ifdef CLINT_VECTOR_EN
  assign target = base + ((csr_mtvec_i[1:0] == 2'b01 && async_q) ? {cause_q[29:0], 2'b00} : 32'd0);
`else
  logic unused_mode;
  assign unused_mode = ^csr_mtvec_i[1:0];
  assign target = base;
`endif
  // Outputs are registered on leaving each state, so each write lands one edge after its state is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      we_o <= 1'b0;
      waddr_o <= '0;
      data_o <= '0;
      int_assert_o <= 1'b0;
      int_addr_o <= '0;
      irq_claim_o <= '0;
      mepc_q <= '0;
      cause_q <= '0;
      src_q <= '0;
      async_q <= 1'b0;
      mret_q <= 1'b0;
    end else begin
      we_o <= 1'b0;
      waddr_o <= '0;
      data_o <= '0;
      int_assert_o <= 1'b0;
      int_addr_o <= '0;
      irq_claim_o <= '0;
      case (state)
        IDLE: begin
          if (sync_req) begin
            state <= MEPC;
            mepc_q <= jump_flag_i ? jump_addr_i - 32'd4 : inst_addr_i;
            cause_q <= is_ecall ? 32'd11 : 32'd3;
            src_q <= '0;
            async_q <= 1'b0;
            mret_q <= 1'b0;
          end else if (async_req) begin
            state <= MEPC;
            mepc_q <= jump_flag_i ? jump_addr_i : div_started_i ? inst_addr_i - 32'd4 : inst_addr_i;
            cause_q <= {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(src)};
            src_q <= src;
            async_q <= 1'b1;
            mret_q <= 1'b0;
          end else if (mret_req) begin
            state <= MRET;
            async_q <= 1'b0;
            mret_q <= 1'b1;
          end
        end
        MEPC: begin
          state <= MSTATUS;
          we_o <= 1'b1;
          waddr_o <= 32'h341;
          data_o <= mepc_q;
        end
        MSTATUS: begin
          state <= MCAUSE;
          we_o <= 1'b1;
          waddr_o <= 32'h300;
          data_o <= {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
        end
        MCAUSE: begin
          state <= ASSERT;
          we_o <= 1'b1;
          waddr_o <= 32'h342;
          data_o <= cause_q;
        end
        MRET: begin
          state <= ASSERT;
          we_o <= 1'b1;
          waddr_o <= 32'h300;
          data_o <= {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
        end
        ASSERT: begin
          state <= IDLE;
          int_assert_o <= 1'b1;
          int_addr_o <= mret_q ? csr_mepc_i : target;
          irq_claim_o <= async_q ? NUM_IRQ'(1) << src_q : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
